// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM link (transmit mux and receive demux).
// Holds the default frame geometry, the slot-index width derivation, the
// slot index type shared with the transmit side, and the lock state type.
package tdm_pkg;

    localparam int NCH_DEF   = 4;
    localparam int WIDTH_DEF = 1;

    // Width of a slot index for a frame of nch channels.
    function automatic int sel_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    localparam int SEL_W_DEF = sel_width(NCH_DEF);

    typedef logic [SEL_W_DEF-1:0] slot_idx_t;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

endpackage

// File: rtl/tdm_demux_if.sv
// Bus bundle between the shared serial line and the demultiplexer.
//   master : line side  - drives din/din_valid/frame_sync, sees the frame
//   slave  : demux side - consumes the line, drives the frame and status
//   din/din_valid/frame_sync : one sample per valid cycle, sync marks slot 0
//   ch_data/frame_valid      : last complete frame and its update strobe
//   slot/locked/sync_err     : alignment status
interface tdm_demux_if
    import tdm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NCH   = NCH_DEF
);
    localparam int SEL_W = sel_width(NCH);

    logic [WIDTH-1:0]     din;
    logic                 din_valid;
    logic                 frame_sync;
    logic [NCH*WIDTH-1:0] ch_data;
    logic                 frame_valid;
    logic [SEL_W-1:0]     slot;
    logic                 locked;
    logic                 sync_err;

    modport master (
        output din, din_valid, frame_sync,
        input  ch_data, frame_valid, slot, locked, sync_err
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output ch_data, frame_valid, slot, locked, sync_err
    );

endinterface

// File: rtl/tdm_slot_ctr.sv
// Slot counter and alignment tracker for the TDM demux.
//   clk, rst : clock, asynchronous active-high reset
//   valid    : a sample is on the line this cycle
//   sync     : the sample is marked as slot 0
//   slot     : slot the next valid non-sync sample fills (registered)
//   locked   : alignment seen since reset (registered)
//   last     : this cycle's sample completes a frame (combinational)
//   misalign : this cycle's sync arrived mid-frame (combinational)
module tdm_slot_ctr
    import tdm_pkg::*;
#(
    parameter  int NCH   = NCH_DEF,
    localparam int SEL_W = sel_width(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic             sync,
    output logic [SEL_W-1:0] slot,
    output logic             locked,
    output logic             last,
    output logic             misalign
);

    localparam logic [SEL_W-1:0] SLOT_TOP = SEL_W'(NCH - 1);

    lock_state_t      state_reg, state_next;
    logic [SEL_W-1:0] slot_reg, slot_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_UNLOCKED;
            slot_reg  <= '0;
        end else begin
            state_reg <= state_next;
            slot_reg  <= slot_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        slot_next  = slot_reg;
        last       = 1'b0;
        misalign   = 1'b0;
        if (valid) begin
            unique case (state_reg)
                ST_UNLOCKED: begin
                    // Unsynced samples are discarded until the first marker.
                    if (sync) begin
                        state_next = ST_LOCKED;
                        slot_next  = SEL_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (sync) begin
                        // A marker at slot 0 is just a regular frame start.
                        misalign  = (slot_reg != '0);
                        slot_next = SEL_W'(1);
                    end else if (slot_reg == SLOT_TOP) begin
                        last      = 1'b1;
                        slot_next = '0;
                    end else begin
                        slot_next = slot_reg + SEL_W'(1);
                    end
                end
                default: state_next = ST_UNLOCKED;
            endcase
        end
    end

    assign slot   = slot_reg;
    assign locked = (state_reg == ST_LOCKED);

endmodule

// File: rtl/tdm_demux.sv
// Receive end of the select-multiplexed serial link. Steers each valid
// sample into a staging slot and publishes a complete registered frame
// with a one-cycle strobe.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : tdm_demux_if slave modport (line in, frame and status out)
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NCH   = NCH_DEF
) (
    input logic        clk,
    input logic        rst,
    tdm_demux_if.slave bus
);

    localparam int SEL_W = sel_width(NCH);

    logic [SEL_W-1:0]     slot;
    logic                 locked;
    logic                 last;
    logic                 misalign;

    // The top channel never needs staging: it comes straight from din.
    logic [WIDTH-1:0]     stage_reg [NCH-1];
    logic [NCH*WIDTH-1:0] ch_data_reg;
    logic                 frame_valid_reg;
    logic                 sync_err_reg;

    tdm_slot_ctr #(.NCH(NCH)) u_slot_ctr (
        .clk      (clk),
        .rst      (rst),
        .valid    (bus.din_valid),
        .sync     (bus.frame_sync),
        .slot     (slot),
        .locked   (locked),
        .last     (last),
        .misalign (misalign)
    );

    generate
        for (genvar gi = 0; gi < NCH - 1; gi++) begin : g_stage
            logic stage_we;
            // A sync sample always lands in slot 0, locked or not.
            assign stage_we = bus.din_valid &&
                              (bus.frame_sync ? (gi == 0)
                                              : (locked && slot == SEL_W'(gi)));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stage_reg[gi] <= '0;
                end else if (stage_we) begin
                    stage_reg[gi] <= bus.din;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ch_data_reg[gi*WIDTH +: WIDTH] <= '0;
                end else if (last) begin
                    ch_data_reg[gi*WIDTH +: WIDTH] <= stage_reg[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_data_reg[(NCH-1)*WIDTH +: WIDTH] <= '0;
            frame_valid_reg                     <= 1'b0;
            sync_err_reg                        <= 1'b0;
        end else begin
            if (last) begin
                ch_data_reg[(NCH-1)*WIDTH +: WIDTH] <= bus.din;
            end
            frame_valid_reg <= last;
            sync_err_reg    <= misalign;
        end
    end

    assign bus.ch_data     = ch_data_reg;
    assign bus.frame_valid = frame_valid_reg;
    assign bus.slot        = slot;
    assign bus.locked      = locked;
    assign bus.sync_err    = sync_err_reg;

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receive end of the 4:1 select-multiplexed serial link. It takes one sample per valid cycle from a shared line, steers it to channel slot A/B/C/D (0..NCH-1) using an internal slot counter aligned by a frame-sync marker, and presents a complete registered frame of all channels with a one-cycle strobe. It sits after the line mux/serializer and feeds per-channel consumers.

## Interface
- `WIDTH`, default 1: bits per sample / per channel.
- `NCH`, default 4: channels per frame, ≥2. `SEL_W = $clog2(NCH)`.
- `clk`  in  1  rising-edge clock, single domain.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  WIDTH  sample on the shared line.
- `din_valid`  in  1  `din` carries a sample this cycle.
- `frame_sync`  in  1  qualifies the current valid sample as slot 0 (channel A). Ignored when `din_valid`=0.
- `ch_data`  out  NCH*WIDTH  last complete frame. Channel k occupies `[k*WIDTH +: WIDTH]`, so channel 0 (A) is in the LSBs.
- `frame_valid`  out  1  one-cycle strobe: `ch_data` has just updated.
- `slot`  out  SEL_W  slot the next valid non-sync sample will fill (the S1:S0 equivalent).
- `locked`  out  1  alignment established since reset.
- `sync_err`  out  1  one-cycle pulse: misplaced `frame_sync` detected.

## Operation
- Reset: `ch_data`=0, `frame_valid`=0, `slot`=0, `locked`=0, `sync_err`=0. The staging register clears to 0.
- Unlocked: valid samples without `frame_sync` are discarded and `slot` holds 0. The first valid sample with `frame_sync` sets `locked`=1, stores to stage[0], and sets `slot`=1.
- Locked, valid sample, no sync: store to stage[`slot`], then `slot`++. When `slot`=NCH-1:
  - Load `ch_data` with stage[0..NCH-2] plus `din` in the top channel.
  - Assert `frame_valid` for one cycle.
  - Wrap `slot` to 0.
- Locked, valid sample with `frame_sync`, `slot`=0: this is normal operation and is handled as slot 0.
- Locked, valid sample with `frame_sync`, `slot`≠0 (misalignment):
  - Drop the partial frame; `ch_data` is unchanged and there is no `frame_valid`.
  - Pulse `sync_err` for one cycle.
  - Treat `din` as slot 0 of a new frame and set `slot`=1.
- `din_valid`=0: counter, stage and outputs hold, and `frame_valid`/`sync_err` drop. Gaps of any length inside a frame are legal.
- `frame_sync` is never required after lock. The counter free-wraps modulo NCH.
- No backpressure: consumers must take `ch_data` on `frame_valid`. `ch_data` holds until the next completed frame.
- Reset mid-frame discards the partial frame immediately and returns to unlocked.

## Timing
- All outputs are registered and there is no combinational path from input to output.
- Latency: `frame_valid` and the new `ch_data` are visible the cycle after the cycle presenting the final slot's valid sample.
- `slot` and `sync_err` update on the same edge that consumes the sample.
- Throughput: one sample per cycle sustained, so one frame per NCH cycles. Back-to-back frames give `frame_valid` every NCH cycles.
- Simultaneous final-slot sample and `frame_sync` with NCH-1≠0: the sync wins. The partial frame is dropped, `sync_err` pulses, and there is no `frame_valid`.

## Structure
- Shared package `tdm_pkg` holds:
  - Default `NCH`/`WIDTH` localparams.
  - The `SEL_W` derivation.
  - The slot index typedef, shared with the transmit-side mux.
- One sub-module, `tdm_slot_ctr`, owns `slot` and `locked`:
  - Inputs: `valid`, `sync`.
  - Outputs: `slot`, `locked`, `last` (slot==NCH-1 && valid && !sync), `misalign`.
- The top level holds the staging register, the `ch_data` output register and the strobes.

## Test plan
- Reset/idle: assert `rst` mid-run → all outputs 0 asynchronously; with `din_valid`=0 nothing changes afterwards.
- Pre-lock discard: WIDTH=1, NCH=4. Valid samples 1,1,1 with no sync → `locked`=0, `slot`=0, no `frame_valid`.
- Basic frame: sync+valid with `din` sequence 1,0,0,1 (A..D) → `frame_valid` for 1 cycle the next cycle, `ch_data`=4'b1001. Then `slot`=0 and `locked`=1.
- Gaps and back-to-back: the same frame with 2 idle cycles between B and C → identical `ch_data`. A second frame 0,1,1,0 with no sync follows directly → `ch_data`=4'b0110 exactly 4 cycles after the previous strobe.
- Misalignment: after lock, send A,B, then sync on the third sample (value 1) followed by 0,0,1 → `sync_err` pulses on the third sample, no strobe for the dropped frame, then `ch_data`=4'b1001.
- Reset mid-frame: lock, send 2 samples, pulse `rst`, then send a clean synced frame 1,1,0,0 → `ch_data`=4'b0011 with no residue from the aborted frame.
